// File: rtl/control_pkg.sv
// control_pkg: RV32I main-decoder opcodes, ALU-op classes and the control bundle.
package control_pkg;
    localparam int OPW = 7;
    localparam logic [OPW-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPW-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPW-1:0] OP_IALU   = 7'b0010011;
    localparam logic [OPW-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPW-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPW-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPW-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPW-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPW-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
        logic       jump;
        logic       jalr;
        logic       lui;
        logic       auipc;
        logic       illegal;
    } ctrl_t;
endpackage

// File: rtl/control_decode.sv
// control_decode: combinational opcode-to-control mapping; bubbles and unknown
// opcodes leave every write strobe low so they have no architectural effect.
module control_decode
    import control_pkg::*;
#(
    parameter int OPW = 7
) (
    input  logic           op_valid,
    input  logic [OPW-1:0] op_code,
    output ctrl_t          ctrl
);
    always_comb begin
        ctrl = '0;
        if (op_valid) begin
            case (op_code)
                OP_RTYPE: begin
                    ctrl.reg_dst   = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = ALUOP_RTYPE;
                end
                OP_LOAD: begin
                    ctrl.alu_src    = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_read   = 1'b1;
                end
                OP_IALU: begin
                    ctrl.alu_src   = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = ALUOP_ITYPE;
                end
                OP_STORE: begin
                    ctrl.alu_src   = 1'b1;
                    ctrl.mem_write = 1'b1;
                end
                OP_BRANCH: begin
                    ctrl.branch = 1'b1;
                    ctrl.alu_op = ALUOP_SUB;
                end
                OP_JAL: begin
                    ctrl.jump      = 1'b1;
                    ctrl.reg_write = 1'b1;
                end
                OP_JALR: begin
                    ctrl.jump      = 1'b1;
                    ctrl.jalr      = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.reg_write = 1'b1;
                end
                OP_LUI: begin
                    ctrl.lui       = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.reg_write = 1'b1;
                end
                OP_AUIPC: begin
                    ctrl.auipc     = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.reg_write = 1'b1;
                end
                default: ctrl.illegal = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/control_unit.sv
// control_unit: RV32I main decoder with a one-cycle, async-reset output register
// feeding the execute-stage pipeline register.
module control_unit
    import control_pkg::*;
#(
    parameter int OPW = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           op_valid,
    input  logic [OPW-1:0] op_code,
    output logic           reg_dst,
    output logic           alu_src,
    output logic           mem_to_reg,
    output logic           reg_write,
    output logic           mem_read,
    output logic           mem_write,
    output logic           branch,
    output logic [1:0]     alu_op,
    output logic           jump,
    output logic           jalr,
    output logic           lui,
    output logic           auipc,
    output logic           illegal
);
    ctrl_t w_ctrl;
    ctrl_t r_ctrl;
    control_decode #(.OPW(OPW)) u_decode (
        .op_valid (op_valid),
        .op_code  (op_code),
        .ctrl     (w_ctrl)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ctrl <= '0;
        else        r_ctrl <= w_ctrl;
    end
    assign reg_dst    = r_ctrl.reg_dst;
    assign alu_src    = r_ctrl.alu_src;
    assign mem_to_reg = r_ctrl.mem_to_reg;
    assign reg_write  = r_ctrl.reg_write;
    assign mem_read   = r_ctrl.mem_read;
    assign mem_write  = r_ctrl.mem_write;
    assign branch     = r_ctrl.branch;
    assign alu_op     = r_ctrl.alu_op;
    assign jump       = r_ctrl.jump;
    assign jalr       = r_ctrl.jalr;
    assign lui        = r_ctrl.lui;
    assign auipc      = r_ctrl.auipc;
    assign illegal    = r_ctrl.illegal;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: vector table, reset corner cases and random decode against a
// literal reference table, with invariants checked every cycle.
module tb_control_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       op_valid = 1'b0;
    logic [6:0] op_code = '0;
    logic reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
    logic [1:0] alu_op;
    logic jump, jalr, lui, auipc, illegal;
    logic [13:0] w_out;
    int n_vec = 0;
    int n_bad = 0;
    logic [13:0] q_exp[$];

    typedef struct {
        string      name;
        logic       valid;
        logic [6:0] op;
        logic [13:0] exp;
    } vec_t;

    // {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op, jump, jalr, lui, auipc, illegal}
    localparam logic [13:0] E_R   = 14'b1_00100010_00000;
    localparam logic [13:0] E_LD  = 14'b0_11110000_00000;
    localparam logic [13:0] E_IA  = 14'b0_10100011_00000;
    localparam logic [13:0] E_ST  = 14'b0_10001000_00000;
    localparam logic [13:0] E_BR  = 14'b0_00000101_00000;
    localparam logic [13:0] E_JAL = 14'b0_00100000_10000;
    localparam logic [13:0] E_JR  = 14'b0_10100000_11000;
    localparam logic [13:0] E_LUI = 14'b0_10100000_00100;
    localparam logic [13:0] E_AUI = 14'b0_10100000_00010;
    localparam logic [13:0] E_ILL = 14'b0_00000000_00001;

    control_unit dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
        .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .alu_op(alu_op), .jump(jump), .jalr(jalr),
        .lui(lui), .auipc(auipc), .illegal(illegal)
    );

    assign w_out = {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
                    branch, alu_op, jump, jalr, lui, auipc, illegal};

    always #5 clk = ~clk;

    function automatic logic [13:0] model(input logic v, input logic [6:0] op);
        if (!v) return '0;
        case (op)
            7'b0110011: return E_R;
            7'b0000011: return E_LD;
            7'b0010011: return E_IA;
            7'b0100011: return E_ST;
            7'b1100011: return E_BR;
            7'b1101111: return E_JAL;
            7'b1100111: return E_JR;
            7'b0110111: return E_LUI;
            7'b0010111: return E_AUI;
            default:    return E_ILL;
        endcase
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive one instruction and compare the output that the following edge registers.
    task automatic cycle(input string name, input logic v, input logic [6:0] op, input logic [13:0] exp);
        logic [13:0] e;
        @(negedge clk);
        op_valid = v;
        op_code  = op;
        q_exp.push_back(exp);
        @(posedge clk);
        #1;
        if (q_exp.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = q_exp.pop_front();
            check(name, w_out, e);
        end
    endtask

    always @(negedge clk) begin
        n_vec++;
        if ((mem_read && mem_write) || (mem_to_reg && !mem_read) ||
            ($countones({branch, jump, lui, auipc, mem_read, mem_write}) > 1) ||
            (illegal && (w_out[13:1] != '0))) begin
            n_bad++;
            $display("FAIL invariant: outputs %b", w_out);
        end
    end

    logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0000011, 7'b0010011, 7'b0100011,
                                  7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    initial begin
        vec_t vecs[$];
        logic       rv;
        logic [6:0] rop;
        vecs = '{
            '{"rtype",  1'b1, 7'b0110011, E_R},
            '{"load",   1'b1, 7'b0000011, E_LD},
            '{"store",  1'b1, 7'b0100011, E_ST},
            '{"branch", 1'b1, 7'b1100011, E_BR},
            '{"ialu",   1'b1, 7'b0010011, E_IA},
            '{"jal",    1'b1, 7'b1101111, E_JAL},
            '{"jalr",   1'b1, 7'b1100111, E_JR},
            '{"lui",    1'b1, 7'b0110111, E_LUI},
            '{"auipc",  1'b1, 7'b0010111, E_AUI},
            '{"illegal",1'b1, 7'b1111111, E_ILL},
            '{"bubble", 1'b0, 7'b1111111, 14'd0},
            '{"bub_ld", 1'b0, 7'b0000011, 14'd0},
            '{"ill_0",  1'b1, 7'b0000000, E_ILL}
        };
        op_valid = 1'b1;
        op_code  = 7'b0000011;
        #1;
        check("reset_state", w_out, 14'd0);
        @(posedge clk);
        #1;
        check("reset_hold", w_out, 14'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_no_edge", w_out, 14'd0);
        @(posedge clk);
        #1;
        check("first_after_release", w_out, E_LD);
        foreach (vecs[i]) cycle(vecs[i].name, vecs[i].valid, vecs[i].op, vecs[i].exp);
        // Reset mid-clock with outputs nonzero, then release with an R-type pending.
        cycle("pre_reset_load", 1'b1, 7'b0000011, E_LD);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", w_out, 14'd0);
        op_code = 7'b1101111;
        @(posedge clk);
        #1;
        check("in_reset_edge", w_out, 14'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op_code = 7'b0110011;
        #1;
        check("after_release", w_out, 14'd0);
        @(posedge clk);
        #1;
        check("rtype_after_reset", w_out, E_R);
        for (int i = 0; i < 1000; i++) begin
            rv  = ($urandom_range(0, 3) != 0);
            rop = ($urandom_range(0, 1) == 1) ? legal_ops[$urandom_range(0, 8)] : 7'($urandom);
            cycle("random", rv, rop, model(rv, rop));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Main decoder for an RV32I single-issue datapath: maps the 7-bit instruction opcode to datapath control strobes and a 2-bit ALU-op class.
- The downstream ALU-control decoder consumes alu_op.
- Sits between instruction fetch/decode and the register file, ALU, data memory and PC-select logic.
- Outputs are registered: one-cycle latency, drives the execute-stage pipeline register.

Parameters:
- OPW, 7, opcode width (fixed by ISA; parameterised only for readability)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- op_valid  input  1  op_code holds a real instruction this cycle; 0 = bubble
- op_code  input  7  instruction bits [6:0]
- reg_dst  output  1  1 = R-type destination select
- alu_src  output  1  1 = ALU operand B is immediate, 0 = rs2
- mem_to_reg  output  1  1 = write-back data from memory
- reg_write  output  1  register-file write enable
- mem_read  output  1  data-memory read strobe
- mem_write  output  1  data-memory write strobe
- branch  output  1  conditional branch
- alu_op  output  2  ALU class: 00 add, 01 compare/subtract, 10 R-type funct decode, 11 I-type funct decode
- jump  output  1  JAL or JALR
- jalr  output  1  JALR (target = rs1 + imm)
- lui  output  1  LUI (result = imm)
- auipc  output  1  AUIPC (result = pc + imm)
- illegal  output  1  op_valid=1 and unrecognised opcode

Behaviour:
- The combinational decode of op_code is captured into output registers on the rising edge of clk. Outputs reflect the op_code sampled at the previous edge (latency 1).
- Reset: rst_n low asynchronously clears every output to 0, with no clock required. Deassertion is released on the next clock edge. Reset asserted mid-stream discards the in-flight decode.
- op_valid=0: all outputs register 0, including illegal (bubble).

Decode table (op_valid=1). Signals listed are 1; all others are 0; alu_op is given explicitly:
- 0110011 R-type: reg_dst, reg_write; alu_op=10. Concatenation {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op} = 00100010.
- 0000011 load: alu_src, mem_to_reg, reg_write, mem_read; alu_op=00. Same concatenation = 11110000.
- 0010011 I-ALU: alu_src, reg_write; alu_op=11.
- 0100011 store: alu_src, mem_write; alu_op=00.
- 1100011 branch: branch; alu_op=01.
- 1101111 JAL: jump, reg_write; alu_op=00.
- 1100111 JALR: jump, jalr, alu_src, reg_write; alu_op=00.
- 0110111 LUI: lui, alu_src, reg_write; alu_op=00.
- 0010111 AUIPC: auipc, alu_src, reg_write; alu_op=00.
- Any other opcode: illegal=1, all other outputs 0. reg_write and mem_write are guaranteed 0, so the instruction has no architectural side effect.

Invariants, checked every cycle:
- mem_read and mem_write never both 1.
- mem_to_reg implies mem_read.
- At most one of {branch, jump, lui, auipc, mem_read, mem_write} is 1.
- illegal=1 implies all other outputs 0.

Decomposition:
- Shared package control_pkg holds:
  - opcode localparams: OP_RTYPE, OP_LOAD, OP_IALU, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
  - ALU-op encodings: ALUOP_ADD, ALUOP_SUB, ALUOP_RTYPE, ALUOP_ITYPE
  - a packed struct ctrl_t bundling all control outputs
- One natural sub-module: control_decode, purely combinational (op_code, op_valid to ctrl_t). control_unit wraps it with the async-reset output register.

Test Plan:
- Reset: assert rst_n=0 mid-clock with outputs nonzero. All outputs go 0 immediately without a clock edge, and stay 0 until the first edge after release.
- R-type: op_code=0110011, op_valid=1. After one edge the concatenation = 00100010, reg_dst=1, illegal=0.
- Load: op_code=0000011. After one edge the concatenation = 11110000, reg_dst=0.
- Sweep the remaining legal opcodes back-to-back, one per cycle: store, branch, I-ALU, JAL, JALR, LUI, AUIPC. Each cycle matches its table row, delayed by exactly one cycle.
- Illegal/bubble:
  - op_code=1111111 gives illegal=1, everything else 0.
  - The same code with op_valid=0 gives all outputs 0.
- Random: 1000 random op_code/op_valid cycles. Compare against a reference-model table with one-cycle delay, and assert every invariant each cycle.
